// File: rtl/bin_2_bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin_2_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int NUM_DIGITS    = 4;
  localparam int OVF_THRESHOLD = 999;
  localparam int ACC_W         = NUM_DIGITS * 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/bin_2_bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bin_2_bcd_add3
  import bin_2_bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Conditional add-3 on one digit
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bin_2_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per cycle, MSB first).
// Define BIN_2_BCD_SATURATE_EN to clamp the reported digits to 9,9,9 on overflow.
module bin_2_bcd
  import bin_2_bcd_pkg::*;
#(
  parameter int BIN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       huns,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Four BCD digits can always hold a 13-bit value; 10 bits is the least that can exceed 999.
  if (BIN_W < 10 || BIN_W > 13 || ((2 ** BIN_W) - 1) <= OVF_THRESHOLD) begin : g_bad_width
    $error("bin_2_bcd: BIN_W must be in 10..13");
  end

  state_t           state_r, state_nxt_s;
  logic             load_s, step_s, last_s;
  logic [CNT_W-1:0] cnt_r;
  logic [BIN_W-1:0] shift_r;
  logic [ACC_W-1:0] acc_r, acc_adj_s, acc_nxt_s;
  bcd_digit_t       thou_s, huns_s, tens_s, ones_s;
  logic             ovf_s;
  logic             done_r, ovf_r;
  bcd_digit_t       huns_r, tens_r, ones_r;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bin_2_bcd_add3 u_add3 (
      .digit    (acc_r[g*4 +: 4]),
      .adjusted (acc_adj_s[g*4 +: 4])
    );
  end

  // The thousands digit never reaches 8 before its last shift, so dropping its MSB is lossless.
  assign acc_nxt_s = ACC_W'({acc_adj_s, shift_r[BIN_W-1]});

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Result digits taken from the accumulator value being written on the final step
  always_comb begin
    thou_s = acc_nxt_s[15:12];
    huns_s = acc_nxt_s[11:8];
    tens_s = acc_nxt_s[7:4];
    ones_s = acc_nxt_s[3:0];
    ovf_s  = (thou_s != 4'd0);
`ifdef BIN_2_BCD_SATURATE_EN
    if (ovf_s) begin
      huns_s = 4'd9;
      tens_s = 4'd9;
      ones_s = 4'd9;
    end else begin
      huns_s = acc_nxt_s[11:8];
      tens_s = acc_nxt_s[7:4];
      ones_s = acc_nxt_s[3:0];
    end
`endif
  end

  // Conversion datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      shift_r <= '0;
      acc_r   <= '0;
      done_r  <= 1'b0;
      huns_r  <= 4'd0;
      tens_r  <= 4'd0;
      ones_r  <= 4'd0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        shift_r <= bin;
        acc_r   <= '0;
        cnt_r   <= '0;
      end else if (step_s) begin
        shift_r <= shift_r << 1;
        acc_r   <= acc_nxt_s;
        cnt_r   <= cnt_r + CNT_W'(1);
      end
      if (last_s) begin
        done_r <= 1'b1;
        huns_r <= huns_s;
        tens_r <= tens_s;
        ones_r <= ones_s;
        ovf_r  <= ovf_s;
      end
    end
  end

  assign busy = (state_r == ST_BUSY);
  assign done = done_r;
  assign huns = huns_r;
  assign tens = tens_r;
  assign ones = ones_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin_2_bcd.sv
// Directed self-checking bench for bin_2_bcd (BIN_W = 12); expectations follow BIN_2_BCD_SATURATE_EN.
module tb_bin_2_bcd;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bin   = 12'd0;
  logic        busy, done, ovf;
  logic [3:0]  huns, tens, ones;

  int checks = 0;
  int fails  = 0;

`ifdef BIN_2_BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  bin_2_bcd #(.BIN_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .huns  (huns),
    .tens  (tens),
    .ones  (ones),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble bin after capture, return edges until done (-1 on timeout).
  task automatic convert(input logic [11:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, huns, tens, ones, ovf} !== 15'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b %0d%0d%0d ovf=%b, want all 0",
               busy, done, huns, tens, ones, ovf);
    end
  endtask

  task automatic test_zero();
    int lat;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    bin   = 12'd0;
    @(negedge clk);
    start = 1'b0;
    bin   = 12'hABC;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 12) begin
      fails++;
      $display("FAIL zero_latency: got %0d, want 12", lat);
    end
    checks++;
    if ({busy, huns, tens, ones, ovf} !== 14'd0) begin
      fails++;
      $display("FAIL zero_result: got busy=%b %0d%0d%0d ovf=%b, want busy=0 000 ovf=0",
               busy, huns, tens, ones, ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_sweep();
    int lat;
    logic [3:0] eh, et, eo;
    for (int v = 0; v < 1000; v++) begin
      convert(12'(v), lat);
      eh = 4'(v / 100);
      et = 4'((v / 10) % 10);
      eo = 4'(v % 10);
      checks++;
      if (lat !== 12) begin
        fails++;
        $display("FAIL sweep_latency v=%0d: got %0d, want 12", v, lat);
      end
      checks++;
      if ({huns, tens, ones, ovf} !== {eh, et, eo, 1'b0}) begin
        fails++;
        $display("FAIL sweep v=%0d: got %0d%0d%0d ovf=%b, want %0d%0d%0d ovf=0",
                 v, huns, tens, ones, ovf, eh, et, eo);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] vals [5] = '{12'd999, 12'd1000, 12'h999, 12'd4095, 12'd1234};
    logic [12:0] raw  [5] = '{{12'h999, 1'b0}, {12'h000, 1'b1}, {12'h457, 1'b1},
                              {12'h095, 1'b1}, {12'h234, 1'b1}};
    logic [12:0] want;
    int lat;
    for (int i = 0; i < 5; i++) begin
      convert(vals[i], lat);
      want = (SAT && raw[i][0]) ? {12'h999, 1'b1} : raw[i];
      checks++;
      if ({huns, tens, ones, ovf} !== want || lat !== 12) begin
        fails++;
        $display("FAIL overflow v=%0d: got %0d%0d%0d ovf=%b lat=%0d, want %h ovf=%b lat=12",
                 vals[i], huns, tens, ones, ovf, lat, want[12:1], want[0]);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    convert(12'd321, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bin = 12'($urandom);
      checks++;
      if ({done, busy, huns, tens, ones, ovf} !== {2'b00, 4'd3, 4'd2, 4'd1, 1'b0}) begin
        fails++;
        $display("FAIL hold cycle %0d: got done=%b busy=%b %0d%0d%0d ovf=%b, want 0 0 321 0",
                 i, done, busy, huns, tens, ones, ovf);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0;
    logic [12:0] seen = 13'd0;
    @(negedge clk);
    start = 1'b1;
    bin   = 12'd123;
    @(negedge clk);
    start = 1'b0;
    bin   = 12'd0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 12'd456;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        seen = {huns, tens, ones, ovf};
      end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL busy_start_pulses: got %0d done pulses, want 1", pulses);
    end
    checks++;
    if (seen !== {4'd1, 4'd2, 4'd3, 1'b0}) begin
      fails++;
      $display("FAIL busy_start_result: got %h, want 1230 (digits,ovf)", seen);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin   = 12'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, huns, tens, ones, ovf} !== 15'd0) begin
      fails++;
      $display("FAIL abort_async_clear: got busy=%b done=%b %0d%0d%0d ovf=%b, want all 0",
               busy, done, huns, tens, ones, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d pulses busy=%b, want 0 pulses busy=0", pulses, busy);
    end
    convert(12'd42, lat);
    checks++;
    if ({huns, tens, ones, ovf} !== {4'd0, 4'd4, 4'd2, 1'b0} || lat !== 12) begin
      fails++;
      $display("FAIL abort_next: got %0d%0d%0d ovf=%b lat=%0d, want 042 ovf=0 lat=12",
               huns, tens, ones, ovf, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    convert(12'd678, lat);
    checks++;
    if ({huns, tens, ones} !== {4'd6, 4'd7, 4'd8} || lat !== 12) begin
      fails++;
      $display("FAIL b2b_first: got %0d%0d%0d lat=%0d, want 678 lat=12", huns, tens, ones, lat);
    end
    start = 1'b1;
    bin   = 12'd901;
    @(negedge clk);
    start = 1'b0;
    bin   = 12'd0;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if ({huns, tens, ones, ovf} !== {4'd9, 4'd0, 4'd1, 1'b0} || lat !== 12) begin
      fails++;
      $display("FAIL b2b_second: got %0d%0d%0d ovf=%b lat=%0d, want 901 ovf=0 lat=12",
               huns, tens, ones, ovf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sweep();
    test_overflow();
    test_hold();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bin_2_bcd.md
BIN_2_BCD -- requirements
Module: bin_2_bcd

Interface
REQ-001 Parameter BIN_W, default 12, binary input width; legal range 10..13; other values SHALL fail elaboration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled on rising clk.
REQ-005 bin  input  BIN_W  unsigned binary value to convert.
REQ-006 busy  output  1  conversion in progress.
REQ-007 done  output  1  one-cycle pulse; result valid.
REQ-008 huns  output  4  BCD hundreds digit, 0..9.
REQ-009 tens  output  4  BCD tens digit, 0..9.
REQ-010 ones  output  4  BCD ones digit, 0..9.
REQ-011 ovf  output  1  high when the converted value exceeds 999.

Function
REQ-012 Algorithm SHALL be iterative shift-add-3 (double dabble), one input bit per cycle, MSB first, with 4 internal digits (thousands..ones).
REQ-013 start && !busy at a rising edge SHALL capture bin, clear the digit accumulator and set busy.
REQ-014 start while busy SHALL be ignored; bin changes after capture SHALL not affect the result.
REQ-015 Each busy cycle SHALL add 3 to every digit >= 5, then shift the accumulator left by one, inserting the next bin bit.
REQ-016 After exactly BIN_W busy cycles busy SHALL drop; done SHALL be high for exactly one cycle; huns/tens/ones/ovf SHALL update in that same cycle.
REQ-017 Latency: start sampled at edge k; done high and results valid after edge k+BIN_W.
REQ-018 start asserted in the done cycle SHALL be accepted (back-to-back conversions, throughput 1 result per BIN_W+1 cycles).
REQ-019 ovf SHALL be 1 iff the thousands digit is nonzero (value > 999).
REQ-020 Digit and ovf outputs SHALL hold their last result until the next done pulse.
REQ-021 Input 0 SHALL produce 0,0,0, ovf=0; input 999 SHALL produce 9,9,9, ovf=0.

Reset
REQ-022 rst_n low SHALL asynchronously clear busy, done, huns, tens, ones, ovf and the accumulator to 0.
REQ-023 Reset during a conversion SHALL abort it; no done pulse SHALL follow reset release.
REQ-024 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-025 Macro BIN_2_BCD_SATURATE_EN defined: when ovf=1, huns/tens/ones SHALL be 9,9,9.
REQ-026 Macro undefined: when ovf=1, huns/tens/ones SHALL be the low three decimal digits (value mod 1000); ovf unaffected by the macro.

Structure
REQ-027 Package bin_2_bcd_pkg SHALL hold the BCD digit typedef (4-bit), the internal digit count constant (4) and the overflow threshold constant (999).
REQ-028 Sub-module bin_2_bcd_add3 SHALL implement the per-digit conditional add-3 cell, instantiated once per internal digit.

Verification
REQ-029 Reset, start with bin=0 -> done 12 cycles later, 0,0,0, ovf=0.
REQ-030 Sweep bin 0..999, one conversion each -> digits match decimal value, ovf=0 throughout.
REQ-031 bin=0x999 (2457) -> ovf=1; digits 4,5,7 without macro, 9,9,9 with BIN_2_BCD_SATURATE_EN.
REQ-032 bin=4095 -> ovf=1; digits 0,9,5 without macro, 9,9,9 with macro.
REQ-033 start bin=123, then start bin=456 on cycle 5 while busy -> only 1,2,3 reported, single done pulse.
REQ-034 start bin=500, rst_n low on cycle 6 -> all outputs 0 immediately, no done pulse; next start bin=42 -> 0,4,2.
